// File: rtl/ifft_4_pkg.sv
// Shared constants and state encoding for the streaming 4-point inverse FFT.
package ifft_4_pkg;

  // Frame length and width of the bin/sample index counter.
  localparam int N     = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/ifft_4_stream_if.sv
// Input and output streaming handshakes of ifft_4_stream, seen from the block (slave)
// and from the environment (master).
interface ifft_4_stream_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] in_r;
  logic [DATA_WIDTH-1:0] in_i;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_r;
  logic [DATA_WIDTH-1:0] out_i;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport slave (
    input  in_r, in_i, in_valid, out_ready,
    output in_ready, out_r, out_i, out_valid, out_last
  );

  modport master (
    output in_r, in_i, in_valid, out_ready,
    input  in_ready, out_r, out_i, out_valid, out_last
  );
endinterface

// File: rtl/ifft_4_core.sv
// Combinational 4-point inverse DFT: two radix-2 butterfly stages with the +j twiddle.
// Results are full precision (DATA_WIDTH+2); scaling/truncation is left to the caller.
module ifft_4_core
  import ifft_4_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic signed [DATA_WIDTH-1:0] x_r [N],
  input  logic signed [DATA_WIDTH-1:0] x_i [N],
  output logic signed [DATA_WIDTH+1:0] y_r [N],
  output logic signed [DATA_WIDTH+1:0] y_i [N]
);

  logic signed [DATA_WIDTH+1:0] e_r [N];
  logic signed [DATA_WIDTH+1:0] e_i [N];
  logic signed [DATA_WIDTH+1:0] a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i;

  // Sign-extend, first stage pairs (X0,X2) and (X1,X3), second stage applies +j on the odd difference.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      e_r[k] = {{2{x_r[k][DATA_WIDTH-1]}}, x_r[k]};
      e_i[k] = {{2{x_i[k][DATA_WIDTH-1]}}, x_i[k]};
    end
    a_r = e_r[0] + e_r[2];
    a_i = e_i[0] + e_i[2];
    b_r = e_r[0] - e_r[2];
    b_i = e_i[0] - e_i[2];
    c_r = e_r[1] + e_r[3];
    c_i = e_i[1] + e_i[3];
    d_r = e_r[1] - e_r[3];
    d_i = e_i[1] - e_i[3];
    // j*d = (-d_i, d_r)
    y_r[0] = a_r + c_r;
    y_i[0] = a_i + c_i;
    y_r[1] = b_r - d_i;
    y_i[1] = b_i + d_r;
    y_r[2] = a_r - c_r;
    y_i[2] = a_i - c_i;
    y_r[3] = b_r + d_i;
    y_i[3] = b_i - d_r;
  end

endmodule

// File: rtl/ifft_4_stream.sv
// Streaming 4-point inverse FFT: load four bins, compute in one cycle, drain four samples.
// Optional macro IFFT_4_SCALE_EN: divide results by 4 (floor) so an fft_4 frame round-trips exactly.
//
// state | meaning
// LOAD  | accepting bins X0..X3 into the input buffer
// CALC  | one cycle: register all four results and present x0
// DRAIN | presenting x0..x3 on the output handshake
module ifft_4_stream
  import ifft_4_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input logic             clk,
  input logic             rst_n,
  ifft_4_stream_if.slave  s
);

  localparam int SW = DATA_WIDTH + 2;

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d, idx_nxt;
  logic                         in_ready_q, in_ready_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0]        out_r_q, out_r_d, out_i_q, out_i_d;
  logic signed [DATA_WIDTH-1:0] bin_r_q [N];
  logic signed [DATA_WIDTH-1:0] bin_i_q [N];
  logic signed [DATA_WIDTH-1:0] bin_r_d [N];
  logic signed [DATA_WIDTH-1:0] bin_i_d [N];
  logic [DATA_WIDTH-1:0]        res_r_q [N];
  logic [DATA_WIDTH-1:0]        res_i_q [N];
  logic [DATA_WIDTH-1:0]        res_r_d [N];
  logic [DATA_WIDTH-1:0]        res_i_d [N];
  logic signed [SW-1:0]         y_r [N];
  logic signed [SW-1:0]         y_i [N];

  ifft_4_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .x_r (bin_r_q),
    .x_i (bin_i_q),
    .y_r (y_r),
    .y_i (y_i)
  );

  function automatic logic [DATA_WIDTH-1:0] fit(input logic signed [SW-1:0] v);
`ifdef IFFT_4_SCALE_EN
    logic signed [SW-1:0] sh;
    sh = v >>> 2;
    return sh[DATA_WIDTH-1:0];
`else
    return v[DATA_WIDTH-1:0];
`endif
  endfunction

  assign s.in_ready  = in_ready_q;
  assign s.out_valid = out_valid_q;
  assign s.out_last  = out_last_q;
  assign s.out_r     = out_r_q;
  assign s.out_i     = out_i_q;

  // Next-state, buffer/result update and registered output selection.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    idx_nxt     = idx_q + IDX_W'(1);
    for (int k = 0; k < N; k++) begin
      bin_r_d[k] = bin_r_q[k];
      bin_i_d[k] = bin_i_q[k];
      res_r_d[k] = res_r_q[k];
      res_i_d[k] = res_i_q[k];
    end
    unique case (state_q)
      LOAD: begin
        if (s.in_valid && in_ready_q) begin
          bin_r_d[idx_q] = s.in_r;
          bin_i_d[idx_q] = s.in_i;
          idx_d          = idx_nxt;
          if (idx_q == IDX_W'(N - 1)) begin
            state_d    = CALC;
            in_ready_d = 1'b0;
          end
        end
      end
      CALC: begin
        for (int k = 0; k < N; k++) begin
          res_r_d[k] = fit(y_r[k]);
          res_i_d[k] = fit(y_i[k]);
        end
        out_r_d     = res_r_d[0];
        out_i_d     = res_i_d[0];
        out_last_d  = 1'b0;
        out_valid_d = 1'b1;
        idx_d       = '0;
        state_d     = DRAIN;
      end
      DRAIN: begin
        if (s.out_ready) begin
          if (idx_q == IDX_W'(N - 1)) begin
            idx_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = LOAD;
          end else begin
            idx_d      = idx_nxt;
            out_r_d    = res_r_q[idx_nxt];
            out_i_d    = res_i_q[idx_nxt];
            out_last_d = (idx_nxt == IDX_W'(N - 1));
          end
        end
      end
      default: begin
        state_d     = LOAD;
        idx_d       = '0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any frame in flight and clears all data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      for (int k = 0; k < N; k++) begin
        bin_r_q[k] <= '0;
        bin_i_q[k] <= '0;
        res_r_q[k] <= '0;
        res_i_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      for (int k = 0; k < N; k++) begin
        bin_r_q[k] <= bin_r_d[k];
        bin_i_q[k] <= bin_i_d[k];
        res_r_q[k] <= res_r_d[k];
        res_i_q[k] <= res_i_d[k];
      end
    end
  end

endmodule

// File: tb/tb_ifft_4_stream.sv
// Self-checking bench for ifft_4_stream: vector table of frames with hand-computed results,
// scoreboard queue filled at stimulus time and drained by an output monitor.
module tb_ifft_4_stream;
  localparam int DW = 64;
  localparam logic [63:0] M1    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M2    = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] M4    = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] P62   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] MAXP  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN  = 64'h8000_0000_0000_0000;

  typedef struct packed {
    logic [3:0][63:0] xr;
    logic [3:0][63:0] xi;
    logic [3:0][63:0] er;
    logic [3:0][63:0] ei;
  } vec_t;

  typedef struct packed {
    logic [63:0] r;
    logic [63:0] i;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_out_cyc = -10;
  int   acc_cyc = 0;
  vec_t tv [8];
  exp_t sb [$];

  ifft_4_stream_if #(.DATA_WIDTH(DW)) bus ();

  ifft_4_stream #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: every transfer is compared against the oldest expected sample.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got %h/%h with empty scoreboard", bus.out_r, bus.out_i);
      end else begin
        e = sb.pop_front();
        check("out_r", bus.out_r, e.r);
        check("out_i", bus.out_i, e.i);
        check("out_last", 64'(bus.out_last), 64'(e.last));
      end
      last_out_cyc = cyc;
    end
  end

  task automatic set_in(input int k, input logic [63:0] r0, i0, r1, i1, r2, i2, r3, i3);
    tv[k].xr[0] = r0; tv[k].xi[0] = i0; tv[k].xr[1] = r1; tv[k].xi[1] = i1;
    tv[k].xr[2] = r2; tv[k].xi[2] = i2; tv[k].xr[3] = r3; tv[k].xi[3] = i3;
  endtask

  task automatic set_exp(input int k, input logic [63:0] r0, i0, r1, i1, r2, i2, r3, i3);
    tv[k].er[0] = r0; tv[k].ei[0] = i0; tv[k].er[1] = r1; tv[k].ei[1] = i1;
    tv[k].er[2] = r2; tv[k].ei[2] = i2; tv[k].er[3] = r3; tv[k].ei[3] = i3;
  endtask

  // Offer one bin and wait (bounded) for it to be accepted; returns 1 ns after the accepting edge.
  task automatic drive_bin(input logic [63:0] r, input logic [63:0] i);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_r = r;
    bus.in_i = i;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc_cyc = cyc;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL in_accept_timeout: in_ready stayed low");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int k, input bit gaps, input bit chk_b2b);
    exp_t e;
    for (int b = 0; b < 4; b++) begin
      e.r = tv[k].er[b];
      e.i = tv[k].ei[b];
      e.last = (b == 3);
      sb.push_back(e);
    end
    for (int b = 0; b < 4; b++) begin
      drive_bin(tv[k].xr[b], tv[k].xi[b]);
      if (b == 0 && chk_b2b)
        check("b2b_first_accept_cycle", 64'(acc_cyc), 64'(last_out_cyc + 1));
      if (gaps && b < 3) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_empty();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_complete", 64'(ok), 64'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_r      = '0;
    bus.in_i      = '0;
    bus.out_ready = 1'b1;

    set_in(0, 64'd10, 64'd0, M2, 64'd2, M2, 64'd0, M2, M2);
    set_in(1, 64'd4, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    set_in(2, M1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    set_in(3, P62, 64'd0, P62, 64'd0, P62, 64'd0, P62, 64'd0);
    set_in(4, MAXP, 64'd0, MAXP, 64'd0, MAXP, 64'd0, MAXP, 64'd0);
    set_in(5, MINN, 64'd0, MINN, 64'd0, MINN, 64'd0, MINN, 64'd0);
    set_in(6, 64'd0, 64'd0, 64'd0, 64'd4, 64'd0, 64'd0, 64'd0, 64'd0);
    set_in(7, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd4, 64'd0);
`ifdef IFFT_4_SCALE_EN
    set_exp(0, 64'd1, 64'd0, 64'd2, 64'd0, 64'd3, 64'd0, 64'd4, 64'd0);
    set_exp(1, 64'd1, 64'd0, 64'd1, 64'd0, 64'd1, 64'd0, 64'd1, 64'd0);
    set_exp(2, M1, 64'd0, M1, 64'd0, M1, 64'd0, M1, 64'd0);
    set_exp(3, P62, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    set_exp(4, MAXP, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    set_exp(5, MINN, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    set_exp(6, 64'd0, 64'd1, M1, 64'd0, 64'd0, M1, 64'd1, 64'd0);
    set_exp(7, 64'd1, 64'd0, 64'd0, M1, M1, 64'd0, 64'd0, 64'd1);
`else
    set_exp(0, 64'd4, 64'd0, 64'd8, 64'd0, 64'd12, 64'd0, 64'd16, 64'd0);
    set_exp(1, 64'd4, 64'd0, 64'd4, 64'd0, 64'd4, 64'd0, 64'd4, 64'd0);
    set_exp(2, M1, 64'd0, M1, 64'd0, M1, 64'd0, M1, 64'd0);
    set_exp(3, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    set_exp(4, M4, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    set_exp(5, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    set_exp(6, 64'd0, 64'd4, M4, 64'd0, 64'd0, M4, 64'd4, 64'd0);
    set_exp(7, 64'd4, 64'd0, 64'd0, M4, M4, 64'd0, 64'd0, 64'd4);
`endif

    // Reset values
    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_out_r", bus.out_r, 64'd0);
    check("rst_out_i", bus.out_i, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test-plan frame with CALC latency check
    send_frame(0, 1'b0, 1'b0);
    check("calc_in_ready", 64'(bus.in_ready), 64'd0);
    check("calc_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("drain_out_valid", 64'(bus.out_valid), 64'd1);
    check("drain_first_r", bus.out_r, tv[0].er[0]);
    wait_empty();

    // Table frames issued back to back
    send_frame(1, 1'b0, 1'b0);
    for (int k = 2; k < 8; k++) send_frame(k, 1'b0, 1'b1);
    wait_empty();

    // Input gaps with an impulse
    send_frame(1, 1'b1, 1'b0);
    wait_empty();

    // Back-pressure at idx=1 for 5 cycles
    bus.out_ready = 1'b0;
    send_frame(0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      check("bp_out_r", bus.out_r, tv[0].er[1]);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_out_last", 64'(bus.out_last), 64'd0);
    end
    bus.out_ready = 1'b1;
    wait_empty();

    // Reset after two input transfers, then a clean frame
    drive_bin(tv[7].xr[0], tv[7].xi[0]);
    drive_bin(tv[7].xr[1], tv[7].xi[1]);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(0, 1'b0, 1'b0);
    wait_empty();

    // Reset while draining discards remaining samples
    bus.out_ready = 1'b0;
    send_frame(6, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("drain_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("drain_rst_out_r", bus.out_r, 64'd0);
    check("drain_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send_frame(3, 1'b0, 1'b0);
    wait_empty();

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
